pipelined_addsub: RTL

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub_pkg.sv | 19 +
 rtl/pipelined_addsub_chunk.sv | 35 +++
 rtl/pipelined_addsub.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_pkg
// Brief    : Shared defaults and per-stage control record for pipelined_addsub.
// Revision : 1.0
// ============================================================================
package pipelined_addsub_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Control bits travelling alongside each operand set through the pipe
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_addsub_chunk.sv
`default_nettype none
// ============================================================================
// Module   : addsub_chunk
// Brief    : Combinational CHUNK_W-bit ripple adder exposing the MSB carry-in.
// Revision : 1.0
// ============================================================================
module addsub_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               ci,
    output logic [CHUNK_W-1:0] sum,
    output logic               co,
    output logic               msb_ci
);

    logic [CHUNK_W:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co     = w_c[CHUNK_W];
    assign msb_ci = w_c[CHUNK_W-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Carry-skewed pipelined adder/subtractor, one chunk per stage,
//            with a single global advance enable for valid/ready flow.
// Revision : 1.0
// ============================================================================
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_addsub: STAGES must be >= 1 and divide WIDTH (>= 2)");
        end
    endgenerate

    logic             w_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Index k: what enters stage k (w_*_in) and what stage k registered (w_*_q)
    stage_ctl_t       w_ctl_in [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];
    stage_ctl_t       w_ctl_q  [STAGES];
    logic [WIDTH-1:0] w_a_q    [STAGES];
    logic [WIDTH-1:0] w_b_q    [STAGES];
    logic [WIDTH-1:0] w_sum_q  [STAGES];
    logic             w_msb_ci [STAGES];
    logic             w_ovf_q;

    assign w_adv    = out_ready | ~w_ctl_q[STAGES-1].valid;
    assign in_ready = w_adv;
    assign w_accept = in_valid & w_adv;

    // Subtraction is a + ~b + 1, so the external carry-in is overridden
    assign w_b_eff  = sub ? ~b : b;
    assign w_c0     = sub | cin;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int c_LO = k * c_CHUNK;

            logic [c_CHUNK-1:0] w_chunk_sum;
            logic               w_co;
            logic [WIDTH-1:0]   w_sum_nx;
            stage_ctl_t         r_ctl;
            logic [WIDTH-1:0]   r_sum;

            if (k == 0) begin : g_head
                assign w_ctl_in[k] = stage_ctl_t'({w_accept, w_c0});
                assign w_a_in[k]   = a;
                assign w_b_in[k]   = w_b_eff;
                assign w_sum_in[k] = '0;
            end else begin : g_link
                assign w_ctl_in[k] = w_ctl_q[k-1];
                assign w_a_in[k]   = w_a_q[k-1];
                assign w_b_in[k]   = w_b_q[k-1];
                assign w_sum_in[k] = w_sum_q[k-1];
            end

            addsub_chunk #(
                .CHUNK_W (c_CHUNK)
            ) u_chunk (
                .a      (w_a_in[k][c_LO +: c_CHUNK]),
                .b      (w_b_in[k][c_LO +: c_CHUNK]),
                .ci     (w_ctl_in[k].carry),
                .sum    (w_chunk_sum),
                .co     (w_co),
                .msb_ci (w_msb_ci[k])
            );

            always_comb begin
                w_sum_nx                  = w_sum_in[k];
                w_sum_nx[c_LO +: c_CHUNK] = w_chunk_sum;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ctl <= '0;
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_ctl <= stage_ctl_t'({w_ctl_in[k].valid, w_co});
                    r_sum <= w_sum_nx;
                end
            end

            assign w_ctl_q[k] = r_ctl;
            assign w_sum_q[k] = r_sum;

            if (k < STAGES - 1) begin : g_skew
                logic [WIDTH-1:0] r_a;
                logic [WIDTH-1:0] r_b;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv) begin
                        r_a <= w_a_in[k];
                        r_b <= w_b_in[k];
                    end
                end

                assign w_a_q[k] = r_a;
                assign w_b_q[k] = r_b;
            end else begin : g_tail
                logic r_ovf;

                // Overflow: carry into the MSB disagrees with carry out of it
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= w_co ^ w_msb_ci[k];
                    end
                end

                assign w_ovf_q  = r_ovf;
                assign w_a_q[k] = '0;
                assign w_b_q[k] = '0;
            end
        end
    endgenerate

    assign out_valid = w_ctl_q[STAGES-1].valid;
    assign sum       = w_sum_q[STAGES-1];
    assign cout      = w_ctl_q[STAGES-1].carry;
    assign ovf       = w_ovf_q;

endmodule
`default_nettype wire
